// File: rtl/multi_timer_pkg.sv
// Shared register map, CTRL field positions and per-channel bus structs for multi_timer.
package multi_timer_pkg;

  localparam logic [3:0] OFF_CTRL     = 4'h0;
  localparam logic [3:0] OFF_COUNT    = 4'h4;
  localparam logic [3:0] OFF_VALUE    = 4'h8;
  localparam logic [3:0] OFF_PRESCALE = 4'hC;
  localparam logic [3:0] CH_GLOBAL    = 4'hF;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_IE   = 1;
  localparam int CTRL_PEND = 2;
  localparam int CTRL_MODE = 3;

  localparam int PSC_W = 16;

  typedef struct packed {
    logic ctrl_we;
    logic value_we;
    logic psc_we;
    logic pend_clr;
  } ch_wr_t;

  typedef struct packed {
    logic [3:0]       ctrl;
    logic [31:0]      count;
    logic [31:0]      value;
    logic [PSC_W-1:0] psc;
  } ch_rd_t;

endpackage

// File: rtl/multi_timer_if.sv
// Register bus between a host (master) and multi_timer (slave).
interface multi_timer_if;
  logic [31:0] data_i;
  logic [31:0] addr_i;
  logic        we_i;
  logic        req_i;
  logic [31:0] data_o;
  logic        int_sig_o;
  logic        ack_o;

  modport master (output data_i, addr_i, we_i, req_i, input data_o, int_sig_o, ack_o);
  modport slave  (input data_i, addr_i, we_i, req_i, output data_o, int_sig_o, ack_o);
endinterface

// File: rtl/multi_timer_channel.sv
// One timer channel: CTRL/VALUE registers, up-counter, pending flag and optional prescaler.
// MULTI_TIMER_PRESCALER_EN adds the PRESCALE register and divider; without it the channel ticks every cycle.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  ch_wr_t      wr,
  input  logic [31:0] wdata,
  output ch_rd_t      rd
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             en, ie, pend, mode;
  logic [WIDTH-1:0] value, count;
  logic             ptick, tick, expire, stop;
  logic             unused_in;

  assign unused_in = ^{wr.psc_we, wdata};
  assign stop      = wr.ctrl_we & ~wdata[CTRL_EN];
  assign tick      = en & (value != '0) & ptick;
  // >= rather than == so a VALUE lowered under the running count expires instead of wrapping
  assign expire    = tick & (count >= value - ONE);

`ifdef MULTI_TIMER_PRESCALER_EN
  logic [PSC_W-1:0] psc, pcnt;

  assign ptick = (pcnt >= psc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc  <= '0;
      pcnt <= '0;
    end else begin
      if (wr.psc_we) psc <= wdata[PSC_W-1:0];
      if (!en || stop || ptick) pcnt <= '0;
      else                      pcnt <= pcnt + 1'b1;
    end
  end

  assign rd.psc = psc;
`else
  assign ptick  = 1'b1;
  assign rd.psc = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en    <= 1'b0;
      ie    <= 1'b0;
      mode  <= 1'b0;
      pend  <= 1'b0;
      value <= '0;
      count <= '0;
    end else begin
      if (wr.ctrl_we) begin
        en   <= wdata[CTRL_EN];
        ie   <= wdata[CTRL_IE];
        mode <= wdata[CTRL_MODE];
      end else if (expire && !mode) begin
        en <= 1'b0;
      end
      // an expiry on the same edge as a clear keeps the channel pending
      if (expire)                                            pend <= 1'b1;
      else if (wr.pend_clr || (wr.ctrl_we && wdata[CTRL_PEND])) pend <= 1'b0;
      if (wr.value_we) value <= wdata[WIDTH-1:0];
      if (stop || !en || value == '0 || expire) count <= '0;
      else if (tick)                            count <= count + ONE;
    end
  end

  assign rd.ctrl  = {mode, pend, ie, en};
  assign rd.count = 32'(count);
  assign rd.value = 32'(value);

endmodule

// File: rtl/multi_timer.sv
// Multi-channel timer: address decode, read mux, INT_STATUS, interrupt and ack around NUM_CH channels.
// Building with MULTI_TIMER_PRESCALER_EN enables the per-channel PRESCALE divider.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32
) (
  input logic          clk,
  input logic          rst,
  multi_timer_if.slave bus
);
  logic [3:0]              ch, off;
  logic                    wr_en, gbl_wr;
  logic                    unused_addr;
  ch_wr_t [NUM_CH-1:0]     wr;
  ch_rd_t [NUM_CH-1:0]     rd;
  logic   [NUM_CH-1:0]     pend_v, ie_v;
  logic   [31:0]           rdata;
  logic                    ack_q, int_q;

  assign ch          = bus.addr_i[7:4];
  assign off         = bus.addr_i[3:0];
  assign unused_addr = ^bus.addr_i[31:8];
  assign wr_en       = bus.req_i & bus.we_i;
  assign gbl_wr      = wr_en & (ch == CH_GLOBAL) & (off == OFF_CTRL);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;
    assign sel   = wr_en & (ch == 4'(i));
    assign wr[i] = '{ctrl_we:  sel & (off == OFF_CTRL),
                     value_we: sel & (off == OFF_VALUE),
                     psc_we:   sel & (off == OFF_PRESCALE),
                     pend_clr: gbl_wr & bus.data_i[i]};

    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk   (clk),
      .rst   (rst),
      .wr    (wr[i]),
      .wdata (bus.data_i),
      .rd    (rd[i])
    );

    assign pend_v[i] = rd[i].ctrl[CTRL_PEND];
    assign ie_v[i]   = rd[i].ctrl[CTRL_IE];
  end

  always_comb begin
    rdata = '0;
    if (bus.req_i) begin
      if (ch == CH_GLOBAL && off == OFF_CTRL) rdata = 32'(pend_v);
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch == 4'(i)) begin
          case (off)
            OFF_CTRL:     rdata = 32'(rd[i].ctrl);
            OFF_COUNT:    rdata = rd[i].count;
            OFF_VALUE:    rdata = rd[i].value;
            OFF_PRESCALE: rdata = 32'(rd[i].psc);
            default:      rdata = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q <= 1'b0;
      int_q <= 1'b0;
    end else begin
      ack_q <= bus.req_i;
      int_q <= |(pend_v & ie_v);
    end
  end

  assign bus.data_o    = rdata;
  assign bus.ack_o     = ack_q;
  assign bus.int_sig_o = int_q;

endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer: directed register traffic, a spec-level reference model checked
// every cycle, and literal expectations for the key timing points.
module tb_multi_timer;
  localparam int NUM_CH = 4;
  localparam int WIDTH  = 32;
`ifdef MULTI_TIMER_PRESCALER_EN
  localparam bit PSC_ON = 1'b1;
`else
  localparam bit PSC_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  multi_timer_if bus();
  multi_timer #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // reference model: register values as the host sees them
  bit     m_en[NUM_CH], m_ie[NUM_CH], m_pend[NUM_CH], m_mode[NUM_CH];
  longint m_val[NUM_CH], m_cnt[NUM_CH], m_phase[NUM_CH];
  longint m_psc[NUM_CH];
  bit     m_ack, m_int;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_en[c] = 0; m_ie[c] = 0; m_pend[c] = 0; m_mode[c] = 0;
      m_val[c] = 0; m_cnt[c] = 0; m_phase[c] = 0; m_psc[c] = 0;
    end
    m_ack = 0;
    m_int = 0;
  endtask

  task automatic model_edge();
    bit          wen = bus.req_i && bus.we_i;
    int          ch  = int'(bus.addr_i[7:4]);
    int          off = int'(bus.addr_i[3:0]);
    logic [31:0] d   = bus.data_i;
    bit          any = 0;
    for (int c = 0; c < NUM_CH; c++) any |= m_pend[c] && m_ie[c];
    m_int = any;
    m_ack = bus.req_i;
    for (int c = 0; c < NUM_CH; c++) begin
      bit mine   = wen && ch == c;
      bit wctrl  = mine && off == 0;
      bit stop   = wctrl && !d[0];
      bit tick   = m_en[c] && m_val[c] != 0 &&
                   (!PSC_ON || (m_phase[c] % (m_psc[c] + 1)) == m_psc[c]);
      bit expire = tick && (m_cnt[c] + 1 >= m_val[c]);
      bit clr    = (wctrl && d[2]) || (wen && ch == 15 && off == 0 && d[c]);
      if (stop || !m_en[c] || m_val[c] == 0 || expire) m_cnt[c] = 0;
      else if (tick) m_cnt[c] = m_cnt[c] + 1;
      m_phase[c] = (stop || !m_en[c]) ? 0 : m_phase[c] + 1;
      if (expire) m_pend[c] = 1;
      else if (clr) m_pend[c] = 0;
      if (wctrl) begin
        m_en[c] = d[0]; m_ie[c] = d[1]; m_mode[c] = d[3];
      end else if (expire && !m_mode[c]) begin
        m_en[c] = 0;
      end
      if (mine && off == 8) m_val[c] = longint'(d) & ((longint'(1) << WIDTH) - 1);
      if (PSC_ON && mine && off == 12) m_psc[c] = longint'(d[15:0]);
    end
  endtask

  function automatic logic [31:0] m_read();
    int          ch  = int'(bus.addr_i[7:4]);
    int          off = int'(bus.addr_i[3:0]);
    logic [31:0] r   = '0;
    if (!bus.req_i) return '0;
    if (ch == 15) begin
      if (off == 0) for (int c = 0; c < NUM_CH; c++) r[c] = m_pend[c];
    end else if (ch < NUM_CH) begin
      case (off)
        0:       r = {28'd0, m_mode[ch], m_pend[ch], m_ie[ch], m_en[ch]};
        4:       r = 32'(m_cnt[ch]);
        8:       r = 32'(m_val[ch]);
        12:      r = 32'(m_psc[ch]);
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_edge();
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("model data_o", bus.data_o, m_read());
      check("model ack_o", 32'(bus.ack_o), 32'(m_ack));
      check("model int_sig_o", 32'(bus.int_sig_o), 32'(m_int));
    end
  end

  task automatic idle();
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.data_i = '0;
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = {24'd0, a}; bus.data_i = d;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic bus_rd(input logic [7:0] a, input logic [31:0] exp, input string name);
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = {24'd0, a}; bus.data_i = '0;
    @(negedge clk);
    check(name, bus.data_o, exp);
    @(posedge clk); #1;
    idle();
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    bus_rd(8'h00, 32'h0, "reset ch0 ctrl");
    bus_rd(8'h38, 32'h0, "reset ch3 value");
    bus_rd(8'hF0, 32'h0, "reset int_status");
    check("reset int_sig_o", 32'(bus.int_sig_o), 32'd0);

    // ch0 one-shot, VALUE=5
    bus_wr(8'h08, 32'd5);
    bus_wr(8'h00, 32'h3);
    check("ack after write", 32'(bus.ack_o), 32'd1);
    wait_cyc(3);
    bus_rd(8'h04, 32'd3, "ch0 count mid-run");
    bus_rd(8'h00, 32'h3, "ch0 ctrl before expiry");
    check("ch0 int not yet", 32'(bus.int_sig_o), 32'd0);
    bus_rd(8'h00, 32'h6, "ch0 one-shot expired");
    check("ch0 int raised", 32'(bus.int_sig_o), 32'd1);
    bus_rd(8'h04, 32'd0, "ch0 count after expiry");
    bus_wr(8'hF0, 32'h1);

    // ch1 periodic, VALUE=3, W1C through CTRL
    bus_wr(8'h18, 32'd3);
    bus_wr(8'h10, 32'hB);
    wait_cyc(3);
    bus_rd(8'h10, 32'hF, "ch1 periodic pending");
    check("ch1 int high", 32'(bus.int_sig_o), 32'd1);
    bus_wr(8'h10, 32'hF);
    check("ch1 int still high", 32'(bus.int_sig_o), 32'd1);
    bus_rd(8'h10, 32'hB, "ch1 pending cleared");
    check("ch1 int dropped", 32'(bus.int_sig_o), 32'd0);
    bus_rd(8'h10, 32'hF, "ch1 pending again");
    bus_wr(8'h10, 32'h4);

    // ch2 prescaled
    bus_wr(8'h2C, 32'd3);
    bus_rd(8'h2C, PSC_ON ? 32'd3 : 32'd0, "ch2 prescale readback");
    bus_wr(8'h28, 32'd2);
    bus_wr(8'h20, 32'h3);
    wait_cyc(PSC_ON ? 7 : 1);
    bus_rd(8'h20, 32'h3, "ch2 before expiry");
    bus_rd(8'h20, 32'h6, "ch2 expired");
    bus_wr(8'h20, 32'h4);

    // ch0 and ch3 expire together with an INT_STATUS clear of ch0
    bus_wr(8'h08, 32'd4);
    bus_wr(8'h38, 32'd5);
    bus_wr(8'h30, 32'h3);
    bus_wr(8'h00, 32'h3);
    wait_cyc(3);
    bus_wr(8'hF0, 32'h1);
    bus_rd(8'hF0, 32'h9, "int_status set wins");
    bus_wr(8'hF0, 32'h9);
    bus_rd(8'hF0, 32'h0, "int_status cleared");

    // VALUE lowered below COUNT, COUNT write ignored
    bus_wr(8'h08, 32'd10);
    bus_wr(8'h00, 32'h3);
    wait_cyc(5);
    bus_wr(8'h04, 32'd99);
    bus_wr(8'h08, 32'd4);
    bus_rd(8'h04, 32'd7, "ch0 count before lowered expiry");
    bus_rd(8'h00, 32'h6, "ch0 lowered value expiry");
    bus_rd(8'h04, 32'd0, "ch0 count cleared");
    bus_rd(8'h01, 32'h0, "unmapped offset");
    bus_wr(8'h48, 32'd55);
    bus_rd(8'h48, 32'h0, "channel beyond NUM_CH");

    // asynchronous reset mid-count
    bus_wr(8'h18, 32'd20);
    bus_wr(8'h10, 32'hB);
    wait_cyc(4);
    bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h14;
    @(posedge clk); #1;
    check("ch1 count pre-reset", bus.data_o, 32'd5);
    check("ack pre-reset", 32'(bus.ack_o), 32'd1);
    check("int pre-reset", 32'(bus.int_sig_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ch1 count in reset", bus.data_o, 32'd0);
    check("ack in reset", 32'(bus.ack_o), 32'd0);
    check("int in reset", 32'(bus.int_sig_o), 32'd0);
    bus.addr_i = 32'h18;
    #1 check("ch1 value in reset", bus.data_o, 32'd0);
    @(posedge clk);
    #4 rst = 1'b0;
    idle();
    wait_cyc(30);
    check("no int after reset", 32'(bus.int_sig_o), 32'd0);
    bus_rd(8'hF0, 32'h0, "int_status after reset");
    bus_rd(8'h14, 32'h0, "ch1 count after reset");
    bus_rd(8'h10, 32'h0, "ch1 ctrl after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 Parameter NUM_CH, 4, number of independent timer channels (legal 1..8).
REQ-002 Parameter WIDTH, 32, counter/compare width (legal 8..32); unused upper data bits read 0, ignored on write.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 data_i  input  32  write data.
REQ-006 addr_i  input  32  address; addr_i[7:4] = channel index (0xF = global), addr_i[3:0] = register offset.
REQ-007 we_i  input  1  write enable, qualified by req_i.
REQ-008 req_i  input  1  bus request.
REQ-009 data_o  output  32  read data.
REQ-010 int_sig_o  output  1  combined interrupt, registered.
REQ-011 ack_o  output  1  bus acknowledge, registered.

Function
REQ-012 Per-channel registers: CTRL 0x0, COUNT 0x4 (read-only), VALUE 0x8, PRESCALE 0xC; global INT_STATUS at addr_i[7:4]=0xF, offset 0x0.
REQ-013 CTRL bits: [0] enable, [1] int enable, [2] pending (write 1 clears), [3] mode (0 one-shot, 1 periodic); other bits read 0.
REQ-014 Write takes effect at the clock edge where req_i=1 and we_i=1; writes to COUNT, unmapped offsets or channel >= NUM_CH are ignored.
REQ-015 Read: data_o is combinational from addr_i when req_i=1; 0 when req_i=0, unmapped, or channel >= NUM_CH.
REQ-016 ack_o is req_i delayed by one cycle; each request cycle yields exactly one ack cycle.
REQ-017 Channel ticks when enable=1, VALUE>0 and prescale tick; COUNT increments by 1 per tick.
REQ-018 Expiry: on a tick with COUNT >= VALUE-1, COUNT <= 0 and pending <= 1 in the same edge.
REQ-019 One-shot expiry additionally clears enable; periodic expiry leaves enable=1.
REQ-020 enable=0 or VALUE=0 holds COUNT at 0; a CTRL write with enable=0 clears COUNT next edge.
REQ-021 VALUE written below current COUNT: next tick expires (>= compare), no wrap through 2^WIDTH.
REQ-022 Simultaneous expiry and pending W1C on same channel: pending stays 1 (set wins).
REQ-023 Simultaneous expiry and CTRL write: bits [0],[1],[3] take written value; pending per REQ-022.
REQ-024 INT_STATUS bit n = channel n pending (read-only); writing 1 to bit n clears it, same priority as REQ-022.
REQ-025 int_sig_o <= OR over channels of (pending & int enable), one cycle after pending changes.

Reset
REQ-026 On rst: CTRL, COUNT, VALUE, PRESCALE, prescale counters, int_sig_o, ack_o all 0, immediately and independent of clk.
REQ-027 Reset mid-count abandons the count; no expiry or interrupt is generated after release until reprogrammed.

Configuration
REQ-028 MULTI_TIMER_PRESCALER_EN defined: PRESCALE[15:0] read/write per channel, tick every PRESCALE+1 cycles, prescale counter clears when enable=0.
REQ-029 MULTI_TIMER_PRESCALER_EN undefined: tick every cycle while enabled; PRESCALE reads 0, writes ignored, no prescale counter logic.

Structure
REQ-030 Shared package holds register offsets, CTRL bit indices, global channel index 0xF and prescaler width 16.
REQ-031 One sub-module timer_channel (counter, prescaler, pending, CTRL/VALUE regs), instantiated NUM_CH times by generate; top holds decode, read mux, INT_STATUS, int_sig_o, ack_o.

Verification
REQ-032 Ch0 VALUE=5, CTRL=0x3 one-shot, no prescale -> pending=1 and enable=0 on 5th edge after write, int_sig_o high next cycle, COUNT=0.
REQ-033 Ch1 VALUE=3, CTRL=0xB periodic -> pending set every 3 cycles, enable stays 1; write CTRL=0xF mid-run clears pending, int_sig_o drops next cycle.
REQ-034 Ch2 PRESCALE=3, VALUE=2, CTRL=0x3 -> expiry exactly 8 cycles after write (macro on); 2 cycles (macro off, PRESCALE reads 0).
REQ-035 Ch0 expiry cycle coincides with INT_STATUS write 0x1 -> pending remains 1; ch3 simultaneous expiry sets INT_STATUS=0x9.
REQ-036 Ch0 COUNT=7 with VALUE=10, write VALUE=4 -> expiry on next tick, COUNT=0; assert rst mid-count -> all registers 0 asynchronously, no int after release.
